// File: rtl/block_checker_pkg.sv
// block_checker_pkg: shared word-state encoding and ASCII constants for block_checker
package block_checker_pkg;
  typedef enum logic [3:0] {IDLE, B, BE, BEG, BEGI, BEGIN, E, EN, END, OTHER} word_state_t;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] CASE_BIT = 8'h20;
  localparam int DEFAULT_DEPTH_W = 32;
endpackage

// File: rtl/block_checker_char_classify.sv
// char_classify: folds ASCII letters to lowercase and flags the word delimiter
module char_classify
  import block_checker_pkg::*;
(
  input  logic [7:0] in,
  output logic [7:0] ch,
  output logic       is_space
);
  assign is_space = in == SPACE;
  assign ch = (in >= "A" && in <= "Z") ? (in | CASE_BIT) : in;
endmodule

// File: rtl/block_checker.sv
// block_checker: streaming begin/end nesting monitor, one ASCII character per clock
module block_checker
  import block_checker_pkg::*;
#(
  parameter int DEPTH_W = DEFAULT_DEPTH_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  output logic       result
);
  localparam logic signed [DEPTH_W-1:0] ONE = 1;
  word_state_t state, nxt;
  logic [7:0] ch;
  logic is_space, broken, inc, dec;
  logic signed [DEPTH_W-1:0] depth, depth_nxt;
  char_classify u_cc (.in(in), .ch(ch), .is_space(is_space));
  always_comb begin
    nxt = is_space                  ? IDLE  :
          (state == IDLE && ch == "b") ? B     :
          (state == IDLE && ch == "e") ? E     :
          (state == B    && ch == "e") ? BE    :
          (state == BE   && ch == "g") ? BEG   :
          (state == BEG  && ch == "i") ? BEGI  :
          (state == BEGI && ch == "n") ? BEGIN :
          (state == E    && ch == "n") ? EN    :
          (state == EN   && ch == "d") ? END   : OTHER;
    // depth tracks the current prefix speculatively; a space leaving BEGIN/END commits it
    inc = nxt == BEGIN || (state == END && nxt == OTHER);
    dec = nxt == END || (state == BEGIN && nxt == OTHER);
    depth_nxt = inc ? depth + ONE : dec ? depth - ONE : depth;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      depth  <= '0;
      broken <= 1'b0;
    end else begin
      state  <= nxt;
      depth  <= depth_nxt;
      broken <= broken | (state == END && is_space && depth < 0);
    end
  end
  assign result = !broken && depth == '0;
endmodule

// File: tb/tb_block_checker.sv
// tb_block_checker: word-level reference model plus literal pins for block_checker
module tb_block_checker;
  logic clk = 0, reset = 0, result;
  logic [7:0] din = 8'h20;
  int pass_cnt = 0, total_cnt = 0;
  bit run = 0;
  string word = "";
  int dep = 0;
  bit brk = 0;
  logic exp_r;

  block_checker dut (.clk(clk), .reset(reset), .in(din), .result(result));

  always #5 clk = ~clk;

  function automatic int kw(string w);
    return w == "begin" ? 1 : w == "end" ? -1 : 0;
  endfunction

  function automatic void model_reset();
    word = ""; dep = 0; brk = 0; exp_r = 1;
  endfunction

  function automatic void model_step(logic [7:0] c);
    logic [7:0] lc;
    if (c == 8'h20) begin
      if (word == "end" && dep - 1 < 0) brk = 1;
      dep += kw(word);
      word = "";
    end else begin
      lc = (c >= "A" && c <= "Z") ? c + 8'h20 : ((c >= "a" && c <= "z") ? c : "#");
      word = $sformatf("%s%c", word, lc);
    end
    exp_r = !brk && (dep + kw(word) == 0);
  endfunction

  task automatic check(string name, logic act, logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: result=%b expected=%b at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) if (run && reset) check("cycle", result, exp_r);

  task automatic send(logic [7:0] c);
    din = c;
    @(posedge clk);
    model_step(c);
    #1;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic pin(string name, logic exp);
    check({name, "_lit"}, result, exp);
    check({name, "_model"}, exp_r, exp);
  endtask

  task automatic do_reset();
    run = 0;
    @(negedge clk);
    reset = 0;
    model_reset();
    #1 check("reset_async", result, 1'b1);
    @(negedge clk);
    reset = 1;
    run = 1;
  endtask

  initial begin
    string toks[12] = '{"begin", "end", "BeGiN", "EnD", "enda", "begins", "x", "b", "beg", "en", "END", "q1"};
    model_reset();
    #12;
    check("reset_state", result, 1'b1);
    reset = 1;
    run = 1;
    send_str("    ");
    pin("idle_spaces", 1);
    send_str(" a BEGi");
    pin("before_n", 1);
    send("n");
    pin("begin_n", 0);
    send(" ");
    pin("begin_commit", 0);
    send_str("end");
    pin("enda_d", 1);
    send("a");
    pin("enda_a", 0);
    send_str(" end");
    pin("end_d", 1);
    send(" ");
    pin("end_commit", 1);
    send_str(" aB end");
    pin("spec_end", 0);
    send("e");
    pin("end_revert", 1);
    send_str("nBEGin");
    pin("other_word", 1);
    do_reset();
    send_str("end");
    pin("lone_end_d", 0);
    send(" ");
    pin("broken_set", 0);
    send_str("begin end ");
    pin("broken_sticky", 0);
    @(posedge clk);
    #3 reset = 0;
    model_reset();
    #1 check("async_clear", result, 1'b1);
    @(negedge clk);
    reset = 1;
    send_str("BEGIN");
    pin("kw1", 0);
    send_str(" begin");
    pin("kw2", 0);
    send_str(" END");
    pin("kw3", 0);
    send_str(" End");
    pin("kw4", 1);
    send_str(" begin1 ");
    pin("begin1", 1);
    send_str("be");
    @(negedge clk);
    reset = 0;
    model_reset();
    #1 check("midword_reset", result, 1'b1);
    @(negedge clk);
    reset = 1;
    send_str("gin ");
    pin("fresh_word", 1);
    for (int r = 0; r < 3000; r++) begin
      if (r % 250 == 0) do_reset();
      case ($urandom_range(0, 3))
        0, 1: send_str(toks[$urandom_range(0, 11)]);
        2: send(8'h20);
        default: send(8'($urandom_range(1, 255)));
      endcase
      if ($urandom_range(0, 1) == 1) send(8'h20);
    end
    run = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
